// File: rtl/gp_rst_seq_pkg.sv
// Shared types and limits for the gp_rst_sequencer reset sequencer.
package gp_rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        DONE     = 2'd2,
        BROWNOUT = 2'd3
    } seq_state_t;

    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 16;
    localparam int STAGE_DELAY_MIN = 1;
    localparam int FILT_MIN        = 1;
    localparam int FILT_MAX        = 255;
    localparam int FILT_CNT_W      = 8;

    // Largest value an unsigned counter of width w can hold.
    function automatic logic [63:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/gp_rst_seq_filter.sv
// VDD_LOW debounce: the flag rises once VDD_LOW has been high on FILT_CYCLES
// consecutive edges and falls on the first edge it is seen low.
module gp_rst_seq_filter
    import gp_rst_seq_pkg::*;
#(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic vdd_low,
    output logic vdd_low_eff
);

    localparam logic [FILT_CNT_W-1:0] RUN_LAST = FILT_CNT_W'(FILT_CYCLES - 1);

    logic [FILT_CNT_W-1:0] run_cnt;

    // run_cnt holds at RUN_LAST while the flag is up, so no wrap is possible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt     <= '0;
            vdd_low_eff <= 1'b0;
        end else if (!vdd_low) begin
            run_cnt     <= '0;
            vdd_low_eff <= 1'b0;
        end else if (run_cnt == RUN_LAST) begin
            vdd_low_eff <= 1'b1;
        end else begin
            run_cnt <= run_cnt + FILT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/gp_rst_sequencer.sv
// Multi-channel power-on reset sequencer with brown-out re-assertion and sticky fault.
// Define BROWNOUT_FILT_EN to debounce VDD_LOW through gp_rst_seq_filter.
module gp_rst_sequencer
    import gp_rst_seq_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int STAGE_DELAY = 500,
    parameter int CNT_W       = 16,
    parameter int FILT_CYCLES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BG_OK,
    input  logic                VDD_LOW,
    input  logic                SOFT_RST,
    input  logic                FAULT_CLR,
    output logic [CHANNELS-1:0] RST_DONE,
    output logic                ALL_DONE,
    output logic                FAULT
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] INDEX_LAST = IDX_W'(CHANNELS - 1);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("gp_rst_sequencer: CHANNELS=%0d out of range", CHANNELS);
    end
    if (STAGE_DELAY < STAGE_DELAY_MIN || 64'(STAGE_DELAY) > cnt_max(CNT_W)) begin : g_bad_delay
        $error("gp_rst_sequencer: STAGE_DELAY=%0d does not fit CNT_W=%0d", STAGE_DELAY, CNT_W);
    end
    if (FILT_CYCLES < FILT_MIN || FILT_CYCLES > FILT_MAX) begin : g_bad_filt
        $error("gp_rst_sequencer: FILT_CYCLES=%0d out of range", FILT_CYCLES);
    end

    seq_state_t          state, state_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [IDX_W-1:0]    index, index_nxt;
    logic [CHANNELS-1:0] rst_done_nxt;
    logic                all_done_nxt;
    logic                fault_nxt;
    logic                vdd_low_eff;

`ifdef BROWNOUT_FILT_EN
    gp_rst_seq_filter #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filter (
        .clk         (CLK),
        .rst         (RST),
        .vdd_low     (VDD_LOW),
        .vdd_low_eff (vdd_low_eff)
    );
`else
    assign vdd_low_eff = VDD_LOW;
`endif

    // Every path into IDLE or BROWNOUT clears the outputs, so IDLE never has to.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        index_nxt    = index;
        rst_done_nxt = RST_DONE;
        all_done_nxt = ALL_DONE;
        fault_nxt    = FAULT_CLR ? 1'b0 : FAULT;

        case (state)
            IDLE: begin
                if (BG_OK && !vdd_low_eff) begin
                    state_nxt = ARM;
                    count_nxt = '0;
                    index_nxt = '0;
                end
            end
            ARM, DONE: begin
                if (vdd_low_eff) begin
                    state_nxt    = BROWNOUT;
                    rst_done_nxt = '0;
                    all_done_nxt = 1'b0;
                    fault_nxt    = 1'b1;
                end else if (SOFT_RST || (state == ARM && !BG_OK)) begin
                    state_nxt    = IDLE;
                    rst_done_nxt = '0;
                    all_done_nxt = 1'b0;
                end else if (state == ARM) begin
                    if (count == COUNT_LAST) begin
                        count_nxt    = '0;
                        rst_done_nxt = RST_DONE | (CHANNELS'(1) << index);
                        if (index == INDEX_LAST) begin
                            all_done_nxt = 1'b1;
                            state_nxt    = DONE;
                        end else begin
                            index_nxt = index + IDX_W'(1);
                        end
                    end else begin
                        count_nxt = count + CNT_W'(1);
                    end
                end
            end
            BROWNOUT: begin
                if (!vdd_low_eff) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            count    <= '0;
            index    <= '0;
            RST_DONE <= '0;
            ALL_DONE <= 1'b0;
            FAULT    <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            index    <= index_nxt;
            RST_DONE <= rst_done_nxt;
            ALL_DONE <= all_done_nxt;
            FAULT    <= fault_nxt;
        end
    end

endmodule
